input_controller: RTL and testbench

// - Input-device front end feeding the control state machine. Buffers words from an external

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/input_fifo.sv | 58 +++++
 rtl/input_controller.sv | 105 ++++++++++
 tb/tb_input_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the CPU control path.
// - ExType codes raised toward the control state machine.
// - Input-controller FSM encodings (legacy 2-bit constants).
// - INT_EN_BIT: bit of the controller's bread status word that enables EX_INPUT.
package cpu_pkg;

  typedef logic [1:0] exType_t;

  localparam exType_t EX_INPUT    = 2'd0;
  localparam exType_t EX_OVFL     = 2'd1;
  localparam exType_t EX_ACCINV   = 2'd2;
  localparam exType_t EX_MISALIGN = 2'd3;

  localparam logic [1:0] IN_IDLE    = 2'd0;
  localparam logic [1:0] IN_PENDING = 2'd1;
  localparam logic [1:0] IN_SERVICE = 2'd2;

  localparam int INT_EN_BIT = 4;

endpackage

// File: rtl/input_fifo.sv
// input_fifo: small circular buffer for input-device words.
// Ports:
//   CLK, Reset      clock, synchronous active-low reset
//   push, wrData    write request and word; ignored while full
//   pop             consume head; ignored while empty
//   rdData          head word, combinational from storage (0 after reset)
//   count           words held
//   full, empty     occupancy flags
module input_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wrData,
  input  logic              pop,
  output logic [DATA_W-1:0] rdData,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic doPush, doPop;

  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdData = mem[rdPtr];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_controller.sv
// input_controller: input-device front end for the control state machine.
// Buffers device words in input_fifo and raises InputRecv (EX_INPUT) while a
// word is waiting and int_en is set. The controller acknowledges by raising
// InputRst (ExH_B); the request re-arms on handler return (KernelMode 1->0).
// Ports:
//   CLK, Reset            clock, synchronous active-low reset
//   dev_valid/dev_data    device word offer; dev_ready accepts it
//   int_en                input-interrupt enable (bread bit INT_EN_BIT)
//   InputRst, KernelMode  controller levels used for ack / return edges
//   in_pop, in_data       CPU read port (head of FIFO), in_count occupancy
//   InputRecv             interrupt request
//   overrun, ovr_clr      sticky drop flag and its clear
// Build option: define INPUT_OVERRUN_EN to accept words unconditionally and
// flag drops on a full FIFO; otherwise the device is backpressured.
import cpu_pkg::*;

module input_controller #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              dev_valid,
  input  logic [DATA_W-1:0] dev_data,
  output logic              dev_ready,
  input  logic              int_en,
  input  logic              InputRst,
  input  logic              KernelMode,
  input  logic              in_pop,
  output logic [DATA_W-1:0] in_data,
  output logic [CNT_W-1:0]  in_count,
  output logic              InputRecv,
  output logic              overrun,
  input  logic              ovr_clr
);

  logic       fifoFull, fifoEmpty;
  logic       inputRstQ, kernelModeQ;
  logic       ack, ret, hasWord;
  logic [1:0] state;

  input_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) uFifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (dev_valid & dev_ready),
    .wrData(dev_data),
    .pop   (in_pop),
    .rdData(in_data),
    .count (in_count),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

`ifdef INPUT_OVERRUN_EN
  // Always ready; the FIFO discards a push while full and we remember it.
  assign dev_ready = 1'b1;

  always_ff @(posedge CLK) begin
    if (!Reset)                      overrun <= 1'b0;
    else if (dev_valid && fifoFull)  overrun <= 1'b1;
    else if (ovr_clr)                overrun <= 1'b0;
  end
`else
  logic unusedOvrClr;
  assign unusedOvrClr = ovr_clr;
  assign dev_ready    = ~fifoFull;
  assign overrun      = 1'b0;
`endif

  assign ack     = InputRst & ~inputRstQ;
  assign ret     = ~KernelMode & kernelModeQ;
  assign hasWord = ~fifoEmpty;

  assign InputRecv = (state == IN_PENDING);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state       <= IN_IDLE;
      inputRstQ   <= 1'b0;
      kernelModeQ <= 1'b0;
    end else begin
      inputRstQ   <= InputRst;
      kernelModeQ <= KernelMode;
      case (state)
        IN_IDLE:
          if (hasWord && int_en) state <= IN_PENDING;
        // Ack takes priority over withdrawal; a word pushed alongside the
        // ack simply waits for the next arm after return.
        IN_PENDING:
          if (ack)          state <= IN_SERVICE;
          else if (!int_en) state <= IN_IDLE;
        // Ack is ignored here; only handler return re-arms.
        IN_SERVICE:
          if (ret) state <= (hasWord && int_en) ? IN_PENDING : IN_IDLE;
        default: state <= IN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_controller.sv
module tb_input_controller;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef INPUT_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              Reset, dev_valid, int_en, InputRst, KernelMode, in_pop, ovr_clr;
  logic [DATA_W-1:0] dev_data;
  logic              dev_ready, InputRecv, overrun;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  in_count;

  input_controller #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .dev_valid(dev_valid), .dev_data(dev_data),
    .dev_ready(dev_ready), .int_en(int_en), .InputRst(InputRst),
    .KernelMode(KernelMode), .in_pop(in_pop), .in_data(in_data),
    .in_count(in_count), .InputRecv(InputRecv), .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: words waiting, request/service flags, sticky drop flag,
  // and the previous levels of the controller handshake signals.
  logic [DATA_W-1:0] q[$];
  bit mReq, mSvc, mOvr, prevRst, prevKm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".count"}, 32'(in_count), 32'(q.size()));
    chk({tag, ".recv"}, 32'(InputRecv), 32'(mReq));
    chk({tag, ".ready"}, 32'(dev_ready), 32'(OVR ? 1'b1 : (q.size() != DEPTH)));
    chk({tag, ".ovr"}, 32'(overrun), 32'(mOvr));
    if (q.size() != 0) chk({tag, ".data"}, 32'(in_data), 32'(q[0]));
  endtask

  // Advance one clock with the current inputs, update the model, then check.
  task automatic step(input string tag);
    int  n;
    bit  ackE, retE, pushE, popE, dropE;
    n = q.size();
    if (!Reset) begin
      q.delete();
      mReq = 0; mSvc = 0; mOvr = 0; prevRst = 0; prevKm = 0;
    end else begin
      ackE  = InputRst && !prevRst;
      retE  = !KernelMode && prevKm;
      pushE = dev_valid && (n < DEPTH);
      popE  = in_pop && (n != 0);
      dropE = OVR && dev_valid && (n == DEPTH);
      if (mSvc) begin
        if (retE) begin mSvc = 0; mReq = (n != 0) && int_en; end
      end else if (mReq) begin
        if (ackE) begin mSvc = 1; mReq = 0; end
        else if (!int_en) mReq = 0;
      end else if ((n != 0) && int_en) mReq = 1;
      if (popE)  void'(q.pop_front());
      if (pushE) q.push_back(dev_data);
      if (dropE) mOvr = 1;
      else if (OVR && ovr_clr) mOvr = 0;
      prevRst = InputRst;
      prevKm  = KernelMode;
    end
    @(posedge CLK);
    #1;
    checkAll(tag);
  endtask

  task automatic idle();
    dev_valid = 0; in_pop = 0; ovr_clr = 0;
  endtask

  initial begin
    Reset = 0; dev_valid = 1; dev_data = 16'hBEEF; int_en = 0;
    InputRst = 0; KernelMode = 1; in_pop = 0; ovr_clr = 0;
    #2;
    // Reset with the device offering a word: nothing lands.
    step("reset0");
    step("reset1");
    chk("reset.data0", 32'(in_data), 32'h0);
    idle(); Reset = 1;
    step("post_reset");

    // Single word raises the request one cycle after it lands.
    int_en = 1; dev_valid = 1; dev_data = 16'h00A5;
    step("push_a5");
    idle();
    step("recv_rise");
    chk("recv_is_1", 32'(InputRecv), 32'h1);
    chk("head_a5", 32'(in_data), 32'h00A5);

    // Ack, hold, release; pop the word and return with an empty FIFO.
    InputRst = 1; step("ack_rise");
    chk("recv_fell", 32'(InputRecv), 32'h0);
    step("ack_hold");
    InputRst = 0; in_pop = 1; step("ack_low_pop");
    in_pop = 0; KernelMode = 0; step("ret_empty");
    step("idle_after_ret");
    chk("stay_idle", 32'(InputRecv), 32'h0);
    KernelMode = 1; step("km_back");

    // Two words, ack, third word during service, then return re-arms.
    dev_valid = 1; dev_data = 16'h1111; step("push_1111");
    dev_data = 16'h2222; step("push_2222");
    idle(); InputRst = 1; step("ack2");
    InputRst = 0; dev_valid = 1; dev_data = 16'h3333; step("push_3333_svc");
    idle(); step("svc_hold");
    chk("no_recv_in_svc", 32'(InputRecv), 32'h0);
    KernelMode = 0; step("ret2");
    chk("rearm_recv", 32'(InputRecv), 32'h1);
    chk("rearm_count", 32'(in_count), 32'h3);
    KernelMode = 1;
    for (int i = 0; i < 3; i++) begin
      in_pop = 1; step("drain");
    end
    in_pop = 0; step("drained");
    chk("empty_count", 32'(in_count), 32'h0);

    // Fill and keep pushing; then push+pop on a full FIFO.
    int_en = 0;
    for (int i = 0; i < 6; i++) begin
      dev_valid = 1; dev_data = 16'(16'hC000 + i); step("fill");
    end
    chk("full_head", 32'(in_data), 32'hC000);
    ovr_clr = 1; dev_valid = 0; step("ovr_clear");
    ovr_clr = 0; dev_valid = 1; dev_data = 16'hD000; in_pop = 1; step("full_push_pop");
    idle(); step("full_pp_after");
    for (int i = 0; i < 4; i++) begin in_pop = 1; step("empty_out"); end
    idle();

    // Wrap: nine push/pop pairs through the ring.
    for (int i = 0; i < 9; i++) begin
      dev_valid = 1; dev_data = 16'(16'h5000 + i); step("wrap_push");
      idle(); in_pop = 1; step("wrap_pop");
      idle();
    end

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      dev_valid  = ($urandom_range(0, 99) < 55);
      dev_data   = 16'($urandom);
      in_pop     = ($urandom_range(0, 99) < 40);
      int_en     = ($urandom_range(0, 99) < 85);
      ovr_clr    = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 15) InputRst = ~InputRst;
      if ($urandom_range(0, 99) < 15) KernelMode = ~KernelMode;
      Reset      = ($urandom_range(0, 199) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
